control_carros: RTL

//  Master game sequencer for the car-dodging display path. Runs the game FSM (ESPERA/JUEGO/CHOQUE)
//  and once per frame moves two obstacle cars and the player car. Detects collisions and keeps

---
 rtl/control_carros.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/control_carros.sv
// control_carros: game sequencer for the car-dodging display (ESPERA/JUEGO/CHOQUE), moves
//   two obstacles and the player once per frame, detects collisions, keeps a saturating score.
// Latency: every state update happens on the iFrameTick cycle and is visible on the outputs
//   the following cycle. There is no backpressure; outputs hold steady for a whole frame.
// Ports:
//   clk, reset (sync, active high), iFrameTick (frame pulse), iStart (level, sampled on tick),
//   iIzq/iDer (debounced buttons) -> oPintarCarros/oPintarJugador (paint enables),
//   oPosicionX1..X3/Y1..Y3 (obstacle boxes, X3/Y3 = wrap tail), oPosicionJugador, oPuntaje, oChoque.
// Optional build macro: CARROS_ACELERACION_EN (obstacle step grows with the score, capped at 15).
module control_carros #(
  parameter int LANE0_X      = 215,
  parameter int LANE1_X      = 340,
  parameter int SPEED        = 4,
  parameter int PLAYER_STEP  = 3,
  parameter int CRASH_FRAMES = 96
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iFrameTick,
  input  logic       iStart,
  input  logic       iIzq,
  input  logic       iDer,
  output logic       oPintarCarros,
  output logic       oPintarJugador,
  output logic [9:0] oPosicionX1,
  output logic [9:0] oPosicionX2,
  output logic [9:0] oPosicionX3,
  output logic [8:0] oPosicionY1,
  output logic [8:0] oPosicionY2,
  output logic [8:0] oPosicionY3,
  output logic [8:0] oPosicionJugador,
  output logic [7:0] oPuntaje,
  output logic       oChoque
);

  typedef enum logic [1:0] {ESPERA = 2'd0, JUEGO = 2'd1, CHOQUE = 2'd2} state_t;

  localparam logic [9:0] L0       = 10'(LANE0_X);
  localparam logic [9:0] L1       = 10'(LANE1_X);
  localparam logic [8:0] PX_RESET = 9'd277;
  localparam logic [8:0] PX_MIN   = 9'd215;
  localparam logic [8:0] PX_MAX   = 9'd340;
  localparam logic [8:0] PSTEP    = 9'(PLAYER_STEP);
  localparam logic [7:0] CNT_LAST = 8'(CRASH_FRAMES - 1);

  state_t      r_state, w_state_next;
  logic [8:0]  r_y1, r_y2, r_px;
  logic [9:0]  r_x1, r_x2;
  logic [7:0]  r_score, r_lfsr, r_cnt;

  // Player box is fixed vertically at 340..429; obstacle boxes are 85x90.
  function automatic logic f_hit(input logic [9:0] ox, input logic [8:0] oy, input logic [8:0] px);
    logic [10:0] v_ox, v_oy, v_px;
    v_ox = {1'b0, ox};
    v_oy = {2'b00, oy};
    v_px = {2'b00, px};
    return (v_px <= v_ox + 11'd84) && (v_ox <= v_px + 11'd84) &&
           (v_oy + 11'd89 >= 11'd340) && (v_oy <= 11'd429);
  endfunction

  logic       w_tick_ok;
  logic       w_collision;
  logic       w_cnt_last;
  logic [4:0] w_step;
  logic [9:0] w_s1, w_s2, w_s1m, w_s2m;
  logic       w_wrap1, w_wrap2;
  logic [9:0] w_lane;
  logic [8:0] w_score_sum;
  logic [7:0] w_score_next;
  logic [8:0] w_px_next;
  logic [9:0] w_px_right;
  logic [7:0] w_lfsr_next;

  assign w_tick_ok   = iFrameTick;
  assign w_collision = f_hit(r_x1, r_y1, r_px) | f_hit(r_x2, r_y2, r_px);
  assign w_cnt_last  = (r_cnt == CNT_LAST);

`ifdef CARROS_ACELERACION_EN
  // One extra pixel per 8 points, never beyond a total step of 15.
  localparam logic [4:0] BONUS_CAP = 5'(15 - SPEED);
  logic [4:0] w_bonus;
  assign w_bonus = (r_score[7:3] > BONUS_CAP) ? BONUS_CAP : r_score[7:3];
  assign w_step  = 5'(SPEED) + w_bonus;
`else
  assign w_step  = 5'(SPEED);
`endif

  assign w_s1    = {1'b0, r_y1} + {5'b0, w_step};
  assign w_s2    = {1'b0, r_y2} + {5'b0, w_step};
  assign w_s1m   = w_s1 - 10'd480;
  assign w_s2m   = w_s2 - 10'd480;
  assign w_wrap1 = (w_s1 >= 10'd480);
  assign w_wrap2 = (w_s2 >= 10'd480);
  // Both obstacles that wrap on the same frame share the lane pick.
  assign w_lane  = r_lfsr[0] ? L1 : L0;

  assign w_score_sum  = {1'b0, r_score} + {8'b0, w_wrap1} + {8'b0, w_wrap2};
  assign w_score_next = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

  assign w_px_right = {1'b0, r_px} + {1'b0, PSTEP};
  always_comb begin
    w_px_next = r_px;
    if (iIzq && !iDer) begin
      w_px_next = (r_px >= PX_MIN + PSTEP) ? (r_px - PSTEP) : PX_MIN;
    end else if (iDer && !iIzq) begin
      w_px_next = (w_px_right >= {1'b0, PX_MAX}) ? PX_MAX : w_px_right[8:0];
    end
  end

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ESPERA;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ESPERA:  if (w_tick_ok && iStart)     w_state_next = JUEGO;
      JUEGO:   if (w_tick_ok && w_collision) w_state_next = CHOQUE;
      CHOQUE:  if (w_tick_ok && w_cnt_last)  w_state_next = ESPERA;
      default: w_state_next = ESPERA;
    endcase
  end

  // Per-frame datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y1    <= 9'd0;
      r_y2    <= 9'd240;
      r_x1    <= L0;
      r_x2    <= L1;
      r_px    <= PX_RESET;
      r_score <= 8'd0;
      r_lfsr  <= 8'hA5;
      r_cnt   <= 8'd0;
    end else if (w_tick_ok) begin
      r_lfsr <= w_lfsr_next;
      case (r_state)
        ESPERA: begin
          if (iStart) begin
            r_y1    <= 9'd0;
            r_y2    <= 9'd240;
            r_x1    <= L0;
            r_x2    <= L1;
            r_px    <= PX_RESET;
            r_score <= 8'd0;
          end
        end
        JUEGO: begin
          // A hit freezes everything, including any wrap that would have happened.
          if (!w_collision) begin
            r_y1    <= w_wrap1 ? w_s1m[8:0] : w_s1[8:0];
            r_y2    <= w_wrap2 ? w_s2m[8:0] : w_s2[8:0];
            if (w_wrap1) r_x1 <= w_lane;
            if (w_wrap2) r_x2 <= w_lane;
            r_score <= w_score_next;
            r_px    <= w_px_next;
          end
        end
        CHOQUE: begin
          r_cnt <= w_cnt_last ? 8'd0 : r_cnt + 8'd1;
        end
        default: r_cnt <= 8'd0;
      endcase
    end
  end

  // Output logic
  always_comb begin
    oPintarCarros  = 1'b0;
    oPintarJugador = 1'b1;
    oChoque        = 1'b0;
    case (r_state)
      JUEGO: oPintarCarros = 1'b1;
      CHOQUE: begin
        oPintarCarros  = 1'b1;
        oPintarJugador = ~r_cnt[3];
        oChoque        = 1'b1;
      end
      default: ;
    endcase
  end

  assign oPosicionX1      = r_x1;
  assign oPosicionX2      = r_x2;
  assign oPosicionX3      = r_x1;
  assign oPosicionY1      = r_y1;
  assign oPosicionY2      = r_y2;
  assign oPosicionY3      = 9'd0;
  assign oPosicionJugador = r_px;
  assign oPuntaje         = r_score;

endmodule
